chacha_stream_ctrl: RTL



---
 rtl/chacha_stream_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: drives chacha_core one 512-bit block at a time and returns results over valid/ready.
// Optional watchdog on the core response is enabled by defining CHACHA_WDOG_EN.
`timescale 1ns/1ps
`default_nettype none

module chacha_stream_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CTR_W       = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [255:0]       cfg_key,
  input  logic [63:0]        cfg_iv,
  input  logic [CTR_W-1:0]   cfg_ctr,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [511:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [511:0]       out_data,
  output logic               out_last,
  output logic               core_init,
  output logic               core_next,
  output logic [255:0]       core_key,
  output logic [CTR_W-1:0]   core_ctr,
  output logic [63:0]        core_iv,
  output logic [511:0]       core_data_in,
  input  logic               core_ready,
  input  logic               core_data_out_valid,
  input  logic [511:0]       core_data_out,
  output logic               ctr_wrap,
  output logic [31:0]        blk_cnt
`ifdef CHACHA_WDOG_EN
  ,
  output logic               wdog_err
`endif
);

  typedef enum logic [2:0] {
    ST_UNKEYED = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [63:0]        iv_q, iv_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [511:0]       data_q, data_d;
  logic               last_q, last_d;
  logic               first_q, first_d;
  logic [511:0]       out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               ctr_wrap_q, ctr_wrap_d;
  logic [31:0]        blk_cnt_q, blk_cnt_d;
`ifdef CHACHA_WDOG_EN
  logic [31:0]        wdog_cnt_q, wdog_cnt_d;
  logic               wdog_err_q, wdog_err_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_UNKEYED;
      key_q      <= '0;
      iv_q       <= '0;
      ctr_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      ctr_wrap_q <= 1'b0;
      blk_cnt_q  <= '0;
`ifdef CHACHA_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      ctr_q      <= ctr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      ctr_wrap_q <= ctr_wrap_d;
      blk_cnt_q  <= blk_cnt_d;
`ifdef CHACHA_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    iv_d       = iv_q;
    ctr_d      = ctr_q;
    data_d     = data_q;
    last_d     = last_q;
    first_d    = first_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    ctr_wrap_d = ctr_wrap_q;
    blk_cnt_d  = blk_cnt_q;
`ifdef CHACHA_WDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
`endif
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;

    case (state_q)
      ST_UNKEYED, ST_IDLE: begin
        cfg_ready = 1'b1;
        // A cfg_load in IDLE takes priority over a pending input block.
        in_ready  = (state_q == ST_IDLE) && !ctr_wrap_q && !cfg_load;
        if (cfg_load) begin
          key_d      = cfg_key;
          iv_d       = cfg_iv;
          ctr_d      = cfg_ctr;
          first_d    = 1'b1;
          ctr_wrap_d = 1'b0;
          blk_cnt_d  = '0;
`ifdef CHACHA_WDOG_EN
          wdog_err_d = 1'b0;
`endif
          state_d    = ST_IDLE;
        end else if (in_valid && in_ready) begin
          data_d  = in_data;
          last_d  = in_last;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = !first_q;
          first_d   = 1'b0;
`ifdef CHACHA_WDOG_EN
          wdog_cnt_d = '0;
`endif
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (core_data_out_valid) begin
          out_data_d = core_data_out;
          out_last_d = last_q;
          blk_cnt_d  = blk_cnt_q + 32'd1;
          // An exhausted counter saturates and flags rather than rolling to zero.
          if (&ctr_q) begin
            ctr_wrap_d = 1'b1;
          end else begin
            ctr_d = ctr_q + {{(CTR_W-1){1'b0}}, 1'b1};
          end
          state_d    = ST_HOLD;
        end
`ifdef CHACHA_WDOG_EN
        else if (wdog_cnt_q == TIMEOUT_CYC - 1) begin
          wdog_err_d = 1'b1;
          state_d    = ST_UNKEYED;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 32'd1;
        end
`endif
      end

      ST_HOLD: begin
        if (out_ready) begin
          state_d = out_last_q ? ST_UNKEYED : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_UNKEYED;
      end
    endcase
  end

  assign out_valid    = (state_q == ST_HOLD);
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign core_key     = key_q;
  assign core_iv      = iv_q;
  assign core_ctr     = ctr_q;
  assign core_data_in = data_q;
  assign ctr_wrap     = ctr_wrap_q;
  assign blk_cnt      = blk_cnt_q;
`ifdef CHACHA_WDOG_EN
  assign wdog_err     = wdog_err_q;
`endif

endmodule

`default_nettype wire
